// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter_pkg                                            |
// | Description : Shared definitions for the two-requester memory arbiter:   |
// |               state encodings, default lock bound, statistics counter    |
// |               widths and a port-to-one-hot helper.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package mem_arbiter_pkg;

    // Arbiter state encodings
    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Default bound on consecutive grants to a locked owner
    localparam int LOCK_MAX_DEFAULT = 8;

    // Statistics counter widths
    localparam int STAT_GRANT_W  = 16;
    localparam int STAT_FORCED_W = 8;

    // Requester index (0/1) to one-hot request mask
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter_rr                                             |
// | Description : Two-way round-robin picker. Purely combinational.          |
// |   i_eligible [1:0] : requesters allowed to win this cycle                |
// |   i_ptr            : favoured requester when both are eligible           |
// |   o_grant    [1:0] : one-hot winner (all zero when nothing eligible)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_eligible;
        if (i_eligible == 2'b11) begin
            o_grant = port_onehot(i_ptr);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-requester round-robin arbiter and sequencer in front   |
// |               of a single-port synchronous memory, with a bounded lock   |
// |               for atomic sequences and 1-cycle read response routing.    |
// | Ports:                                                                   |
// |   clk, reset_n          : clock, asynchronous active-low reset           |
// |   req_valid/ready [1:0] : per-requester handshake (ready combinational)  |
// |   req_we/lock     [1:0] : write select, hold-grant request               |
// |   req_add, req_dat      : packed per-requester address / write data      |
// |   rsp_valid [1:0]       : read-data pulse for the issuing requester      |
// |   rsp_dat               : shared read data (0 when no response)          |
// |   mem_en/we/add/din     : memory command port                            |
// |   mem_dout              : memory read data, valid the cycle after en     |
// | Optional (MEM_ARBITER_STATS_EN):                                         |
// |   stat_grant0/1         : saturating per-requester transfer counts       |
// |   stat_forced           : saturating count of lock-bound releases        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADD_WIDTH = 10,
    parameter int DAT_WIDTH = 8,
    parameter int LOCK_MAX  = LOCK_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0]             req_lock,
    input  logic [2*ADD_WIDTH-1:0] req_add,
    input  logic [2*DAT_WIDTH-1:0] req_dat,
    output logic [1:0]             rsp_valid,
    output logic [DAT_WIDTH-1:0]   rsp_dat,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADD_WIDTH-1:0]   mem_add,
    output logic [DAT_WIDTH-1:0]   mem_din,
    input  logic [DAT_WIDTH-1:0]   mem_dout
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [STAT_GRANT_W-1:0]  stat_grant0,
    output logic [STAT_GRANT_W-1:0]  stat_grant1,
    output logic [STAT_FORCED_W-1:0] stat_forced
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    // Count value at which the next owner transfer is the last one allowed
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(LOCK_MAX - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic             r_owner, w_owner_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_ptr,   w_ptr_nxt;
    logic             r_rsp_vld;
    logic             r_rsp_port;

    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_xfer;
    logic             w_port;
    logic             w_forced;

    // While locked only the owner may win; nothing is granted in reset.
    always_comb begin
        w_elig = req_valid;
        if (!reset_n) begin
            w_elig = 2'b00;
        end else if (r_state == ST_LOCKED) begin
            w_elig = req_valid & port_onehot(r_owner);
        end
    end

    mem_arbiter_rr u_rr (
        .i_eligible (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant)
    );

    assign w_xfer = |w_grant;
    assign w_port = w_grant[1];

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_forced    = 1'b0;

        if (w_xfer) begin
            w_ptr_nxt = ~w_port;
        end

        case (r_state)
            ST_ARB: begin
                if (w_xfer && req_lock[w_port]) begin
                    if (LOCK_MAX > 1) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_port;
                        w_cnt_nxt   = CNT_W'(1);
                    end else begin
                        // A bound of one is already exhausted by this grant
                        w_forced = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_xfer) begin
                    if (r_cnt >= c_cnt_last) begin
                        // Bound reached: release; the pointer already
                        // favours the other requester after this grant.
                        w_state_nxt = ST_ARB;
                        w_cnt_nxt   = '0;
                        w_forced    = req_lock[r_owner];
                    end else if (req_lock[r_owner]) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        w_state_nxt = ST_ARB;
                        w_cnt_nxt   = '0;
                    end
                end else if (!req_lock[r_owner]) begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_ARB;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_ptr      <= 1'b0;
            r_rsp_vld  <= 1'b0;
            r_rsp_port <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ptr      <= w_ptr_nxt;
            // Response tag: which requester issued a read last cycle
            r_rsp_vld  <= w_xfer & ~req_we[w_port];
            r_rsp_port <= w_port;
        end
    end

    assign req_ready = w_grant;
    assign mem_en    = w_xfer;
    assign mem_we    = w_xfer & req_we[w_port];
    assign mem_add   = !w_xfer ? '0 :
                       (w_port ? req_add[2*ADD_WIDTH-1:ADD_WIDTH] : req_add[ADD_WIDTH-1:0]);
    assign mem_din   = !w_xfer ? '0 :
                       (w_port ? req_dat[2*DAT_WIDTH-1:DAT_WIDTH] : req_dat[DAT_WIDTH-1:0]);
    assign rsp_valid = r_rsp_vld ? port_onehot(r_rsp_port) : 2'b00;
    assign rsp_dat   = r_rsp_vld ? mem_dout : '0;

`ifdef MEM_ARBITER_STATS_EN
    logic [STAT_GRANT_W-1:0]  r_stat_g0;
    logic [STAT_GRANT_W-1:0]  r_stat_g1;
    logic [STAT_FORCED_W-1:0] r_stat_forced;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_g0     <= '0;
            r_stat_g1     <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_xfer && !w_port && (r_stat_g0 != '1)) begin
                r_stat_g0 <= r_stat_g0 + 1'b1;
            end
            if (w_xfer && w_port && (r_stat_g1 != '1)) begin
                r_stat_g1 <= r_stat_g1 + 1'b1;
            end
            if (w_forced && (r_stat_forced != '1)) begin
                r_stat_forced <= r_stat_forced + 1'b1;
            end
        end
    end

    assign stat_grant0 = r_stat_g0;
    assign stat_grant1 = r_stat_g1;
    assign stat_forced = r_stat_forced;
`else
    // Forced-release detection only feeds the statistics counters
    logic w_unused_forced;
    assign w_unused_forced = w_forced;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Self-checking bench for mem_arbiter. Requester traffic is  |
// |               held in per-port queues; a transaction-level reference     |
// |               (pointer, lock owner, grants-in-burst, memory image)       |
// |               predicts every output each cycle.                          |
// |               Build with MEM_ARBITER_STATS_EN to also check counters.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int LM = 8;

    typedef struct {
        bit            we;
        bit            lock;
        logic [AW-1:0] add;
        logic [DW-1:0] dat;
    } txn_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [1:0]      req_lock;
    logic [2*AW-1:0] req_add;
    logic [2*DW-1:0] req_dat;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_dat;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_add;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0]     stat_grant0;
    logic [15:0]     stat_grant1;
    logic [7:0]      stat_forced;
`endif

    mem_arbiter #(.ADD_WIDTH(AW), .DAT_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_add   (req_add),
        .req_dat   (req_dat),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_add   (mem_add),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .stat_grant0 (stat_grant0),
        .stat_grant1 (stat_grant1),
        .stat_forced (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory attached to the arbiter
    logic [DW-1:0] mem_arr [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_add] <= mem_din;
            else        mem_dout <= mem_arr[mem_add];
        end
    end

    // Reference state
    logic [DW-1:0] ref_mem [0:1023];
    int            m_ptr;
    int            m_owner;      // -1 when no lock is held
    int            m_burst;      // grants given to the current lock owner
    bit            m_rsp_pend;
    int            m_rsp_port;
    logic [DW-1:0] m_rsp_dat;
    int            m_g0, m_g1, m_forced;

    txn_t          q0[$];
    txn_t          q1[$];
    logic [1:0]    idle_lock;
    logic [1:0]    rlog[$];
    logic [1:0]    last_rsp_v;
    logic [DW-1:0] last_rsp_d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_burst = 0; m_rsp_pend = 0;
        m_rsp_port = 0; m_rsp_dat = '0;
        m_g0 = 0; m_g1 = 0; m_forced = 0;
    endtask

    // One clock cycle: drive queue heads, check outputs, advance the model.
    // Entered and left at a falling edge.
    task automatic run_cycle();
        txn_t          t;
        logic [1:0]    v, lk, elig, g, ev;
        logic [DW-1:0] ed;
        int            p;
        v = {q1.size() > 0, q0.size() > 0};
        lk = idle_lock;
        req_we = 2'b00; req_add = '0; req_dat = '0;
        if (v[0]) begin
            lk[0] = q0[0].lock; req_we[0] = q0[0].we;
            req_add[AW-1:0] = q0[0].add; req_dat[DW-1:0] = q0[0].dat;
        end
        if (v[1]) begin
            lk[1] = q1[0].lock; req_we[1] = q1[0].we;
            req_add[2*AW-1:AW] = q1[0].add; req_dat[2*DW-1:DW] = q1[0].dat;
        end
        req_valid = v;
        req_lock  = lk;
        #1;
        elig = reset_n ? v : 2'b00;
        if (m_owner >= 0) elig = elig & ((m_owner == 1) ? 2'b10 : 2'b01);
        if (elig == 2'b11) g = (m_ptr == 1) ? 2'b10 : 2'b01;
        else               g = elig;
        p = g[1] ? 1 : 0;
        t = '{we: 1'b0, lock: 1'b0, add: '0, dat: '0};
        if (g != 2'b00) t = (p == 1) ? q1[0] : q0[0];
        ev = (reset_n && m_rsp_pend) ? ((m_rsp_port == 1) ? 2'b10 : 2'b01) : 2'b00;
        ed = (ev != 2'b00) ? m_rsp_dat : '0;

        chk("req_ready", 32'(req_ready), 32'(g));
        chk("mem_en",    32'(mem_en),    32'(g != 2'b00));
        chk("mem_we",    32'(mem_we),    32'(t.we));
        chk("mem_add",   32'(mem_add),   32'(t.add));
        chk("mem_din",   32'(mem_din),   32'(t.dat));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_dat",   32'(rsp_dat),   32'(ed));
        rlog.push_back(req_ready);
        last_rsp_v = rsp_valid;
        last_rsp_d = rsp_dat;

        if (!reset_n) begin
            model_reset();
        end else begin
            m_rsp_pend = 0;
            if (g != 2'b00) begin
                if (t.we) ref_mem[t.add] = t.dat;
                else begin
                    m_rsp_pend = 1; m_rsp_port = p; m_rsp_dat = ref_mem[t.add];
                end
                if (p == 1) m_g1++; else m_g0++;
                m_ptr = 1 - p;
                if (m_owner < 0) begin
                    if (t.lock) begin
                        if (LM > 1) begin m_owner = p; m_burst = 1; end
                        else m_forced++;
                    end
                end else begin
                    m_burst++;
                    if (m_burst >= LM) begin
                        if (t.lock) m_forced++;
                        m_owner = -1;
                    end else if (!t.lock) begin
                        m_owner = -1;
                    end
                end
                if (p == 1) void'(q1.pop_front()); else void'(q0.pop_front());
            end else if (m_owner >= 0 && !lk[m_owner]) begin
                m_owner = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q0.size() + q1.size()) > 0 && n < budget) begin
            run_cycle();
            n++;
        end
        chk(tag, 32'(q0.size() + q1.size()), 32'd0);
        q0.delete(); q1.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run_cycle();
        reset_n = 1'b1;
    endtask

    function automatic txn_t mk(input bit we, input bit lock, input int add, input int dat);
        txn_t t;
        t.we = we; t.lock = lock; t.add = AW'(add); t.dat = DW'(dat);
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_c [4];
        logic [1:0] exp_l [4];
        reset_n = 1'b0; idle_lock = 2'b00;
        req_valid = 2'b00; req_we = 2'b00; req_lock = 2'b00; req_add = '0; req_dat = '0;
        model_reset();
        @(negedge clk);

        // Reset state with both requesters presenting writes
        q0.push_back(mk(1, 0, 5, 0));
        q1.push_back(mk(1, 0, 6, 0));
        run_cycle();
        run_cycle();
        reset_n = 1'b1;
        drain("reset_drain", 10);

        // Initialise the low memory image through the arbiter
        for (int a = 0; a < 64; a++) begin
            if (a % 2 == 0) q0.push_back(mk(1, 0, a, $urandom_range(0, 255)));
            else            q1.push_back(mk(1, 0, a, $urandom_range(0, 255)));
        end
        drain("init_drain", 200);

        // Single read after write
        q0.push_back(mk(1, 0, 5, 8'hA5));
        drain("wr_drain", 5);
        q0.push_back(mk(0, 0, 5, 0));
        rlog.delete();
        run_cycle();
        run_cycle();
        chk("single_ready", 32'(rlog[0]), 32'h1);
        chk("single_rsp_v", 32'(last_rsp_v), 32'h1);
        chk("single_rsp_d", 32'(last_rsp_d), 32'hA5);

        // Contention after reset: 0,1,0,1
        do_reset();
        rlog.delete();
        q0.push_back(mk(0, 0, 'h010, 0)); q0.push_back(mk(0, 0, 'h010, 0));
        q1.push_back(mk(0, 0, 'h020, 0)); q1.push_back(mk(0, 0, 'h020, 0));
        drain("cont_drain", 10);
        run_cycle();
        exp_c = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int k = 0; k < 4; k++) chk("cont_grant", 32'(rlog[k]), 32'(exp_c[k]));

        // Lock by port 1 while port 0 waits
        q0.push_back(mk(0, 0, 'h030, 0));
        run_cycle();
        rlog.delete();
        q0.push_back(mk(0, 0, 'h031, 0));
        q1.push_back(mk(1, 1, 'h040, 'h11));
        q1.push_back(mk(1, 1, 'h041, 'h22));
        q1.push_back(mk(1, 0, 'h042, 'h33));
        drain("lock_drain", 10);
        exp_l = '{2'b10, 2'b10, 2'b10, 2'b01};
        for (int k = 0; k < 4; k++) chk("lock_grant", 32'(rlog[k]), 32'(exp_l[k]));

        // Forced release after LM grants
        do_reset();
        rlog.delete();
        for (int k = 0; k < 12; k++) q0.push_back(mk(1, 1, 'h100 + k, k));
        q1.push_back(mk(1, 0, 'h200, 'h77));
        drain("forced_drain", 30);
        chk("forced_len", 32'(rlog.size()), 32'd13);
        for (int k = 0; k < 13; k++)
            chk("forced_grant", 32'(rlog[k]), (k == 8) ? 32'h2 : 32'h1);
`ifdef MEM_ARBITER_STATS_EN
        chk("stat_grant0", 32'(stat_grant0), 32'd12);
        chk("stat_grant1", 32'(stat_grant1), 32'd1);
        chk("stat_forced", 32'(stat_forced), 32'd1);
`endif

        // Reset in the cycle after a read grant
        q0.push_back(mk(0, 0, 5, 0));
        run_cycle();
        reset_n = 1'b0;
        q1.push_back(mk(0, 0, 6, 0));
        run_cycle();
        chk("rst_rsp_v", 32'(last_rsp_v), 32'h0);
        reset_n = 1'b1;
        rlog.delete();
        q0.push_back(mk(0, 0, 7, 0));
        run_cycle();
        chk("rst_ptr0", 32'(rlog[0]), 32'h1);
        drain("rst_drain", 10);

        // Randomised traffic with locks and idle-lock holds
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) != 0)
                q0.push_back(mk($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                                $urandom_range(0, 63), $urandom_range(0, 255)));
            if (q1.size() == 0 && $urandom_range(0, 3) != 0)
                q1.push_back(mk($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                                $urandom_range(0, 63), $urandom_range(0, 255)));
            idle_lock = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            run_cycle();
        end
        idle_lock = 2'b00;
        drain("rand_drain", 50);
        run_cycle();
`ifdef MEM_ARBITER_STATS_EN
        chk("rand_stat_g0", 32'(stat_grant0), 32'(m_g0));
        chk("rand_stat_g1", 32'(stat_grant1), 32'(m_g1));
        chk("rand_stat_forced", 32'(stat_forced), 32'(m_forced));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
